// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel prefetch path.
//   H_ACTIVE / V_ACTIVE : visible raster size
//   FRAME_PIXELS        : pixels fetched per frame
//   ADDR_W / PIX_W      : frame-memory address and pixel word widths
//   fetch_state_t       : prefetch sequencer states
package vga_pkg;
  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W       = 19;
  localparam int PIX_W        = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_flush        : empties the FIFO (pointers and count to zero)
//   i_push/i_wdata : write port; a push into a full FIFO is ignored
//                    unless a pop frees a slot in the same cycle
//   i_pop          : advance the head; ignored when empty
//   o_rdata        : head word, forced to 0 while empty
//   o_valid        : FIFO non-empty
//   o_count        : words held
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = i_pop && (count != '0);
  assign do_push = i_push && ((count != CNT_FULL) || do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; the zero mask on o_rdata hides stale contents.
  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) mem[wr_ptr] <= i_wdata;
  end

  assign o_valid = (count != '0);
  assign o_rdata = o_valid ? mem[rd_ptr] : '0;
  assign o_count = count;
endmodule

// File: rtl/vga_pixel_prefetch.sv
// Frame-memory prefetcher feeding the VGA pixel pipeline.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_frame_start       : restart fetching at pixel 0 (flushes FIFO)
//   i_pix_rd            : pop one pixel from the FIFO head
//   o_pix_data/valid    : show-ahead FIFO head {8'h0,R,G,B} and non-empty
//   o_underflow         : sticky, set by a pop on an empty FIFO
//   o_mem_req/addr      : read request to frame memory
//   i_mem_ack           : request accepted when high with o_mem_req
//   i_mem_rvalid/rdata  : in-order read returns
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | after reset, no frame started, no requests
// ST_FETCH | issuing requests under the FIFO credit limit
// ST_DONE  | last pixel of the frame requested, awaiting next frame
module vga_pixel_prefetch
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_PIXELS = vga_pkg::FRAME_PIXELS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_start,
  input  logic              i_pix_rd,
  output logic [PIX_W-1:0]  o_pix_data,
  output logic              o_pix_valid,
  output logic              o_underflow,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic              i_mem_rvalid,
  input  logic [PIX_W-1:0]  i_mem_rdata
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]    DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);

  fetch_state_t     state;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard_count;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_used;
  logic             accept;
  logic             drop;
  logic             push;
  logic             pop;

  // Request is combinational from registered counters so the credit
  // limit holds exactly in the cycle an ack or return lands.
  // A frame_start cycle never issues: the address is about to rewind.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
  assign o_mem_req   = (state == ST_FETCH) && (discard_count == '0) &&
                       !i_frame_start && (credit_used < DEPTH_EXT);
  assign accept      = o_mem_req && i_mem_ack;

  // Returns belonging to the previous frame (already in flight at
  // frame_start, including one landing in that very cycle) are dropped.
  assign drop = i_mem_rvalid && (i_frame_start || (discard_count != '0));
  assign push = i_mem_rvalid && !drop;
  assign pop  = i_pix_rd && !i_frame_start;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      o_mem_addr  <= '0;
      o_underflow <= 1'b0;
    end else if (i_frame_start) begin
      state       <= ST_FETCH;
      o_mem_addr  <= '0;
      o_underflow <= 1'b0;
    end else begin
      if (i_pix_rd && !o_pix_valid) o_underflow <= 1'b1;
      if (accept) begin
        o_mem_addr <= o_mem_addr + ADDR_ONE;
        if (o_mem_addr == LAST_ADDR) state <= ST_DONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      outstanding   <= '0;
      discard_count <= '0;
    end else begin
      case ({accept, i_mem_rvalid})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase

      // accept is never high with frame_start, so the new discard value
      // equals what remains in flight after this cycle.
      if (i_frame_start)
        discard_count <= i_mem_rvalid ? outstanding - CNT_ONE : outstanding;
      else if (i_mem_rvalid && (discard_count != '0))
        discard_count <= discard_count - CNT_ONE;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_frame_start),
    .i_push  (push),
    .i_wdata (i_mem_rdata),
    .i_pop   (pop),
    .o_rdata (o_pix_data),
    .o_valid (o_pix_valid),
    .o_count (fifo_count)
  );
endmodule

// File: tb/tb_vga_pixel_prefetch.sv
// Bench for vga_pixel_prefetch: directed phases, a queue-based model of
// the frame memory and pixel FIFO, and literal checks on key results.
module tb_vga_pixel_prefetch;
  import vga_pkg::*;

  localparam int DEPTH = 16;
  localparam int FP    = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        pix_rd;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        underflow;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  vga_pixel_prefetch #(.FIFO_DEPTH(DEPTH), .FRAME_PIXELS(FP)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_frame_start (frame_start),
    .i_pix_rd      (pix_rd),
    .o_pix_data    (pix_data),
    .o_pix_valid   (pix_valid),
    .o_underflow   (underflow),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .i_mem_ack     (mem_ack),
    .i_mem_rvalid  (mem_rvalid),
    .i_mem_rdata   (mem_rdata)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  // Model: pixels the FIFO must hold, requests in flight, how many of
  // those in-flight requests belong to an abandoned frame.
  logic [31:0] m_fifo[$];
  int          mq_addr[$];
  int          mq_due[$];
  int          stale     = 0;
  int          next_addr = 0;
  bit          started   = 0;
  bit          m_uflow   = 0;
  bit          exp_req;

  int          acc_log[$];
  logic [31:0] pop_log[$];

  function automatic logic [31:0] pix_of(input int a);
    logic [23:0] v;
    v = 24'(a) ^ 24'hC0FFEE;
    return {8'h00, v};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    mq_addr.delete();
    mq_due.delete();
    acc_log.delete();
    pop_log.delete();
    stale     = 0;
    next_addr = 0;
    started   = 0;
    m_uflow   = 0;
  endtask

  // Entered at posedge+1; checks registered outputs, drives one cycle of
  // inputs, checks the request, advances the model, waits for the edge.
  task automatic cycle(input bit fs, input bit rd, input bit ack);
    bit ret;
    int ra;
    bit acc;
    chk("pix_valid", 32'(pix_valid), 32'(m_fifo.size() != 0));
    chk("pix_data", pix_data, (m_fifo.size() != 0) ? m_fifo[0] : 32'h0);
    chk("underflow", 32'(underflow), 32'(m_uflow));
    chk("mem_addr", 32'(mem_addr), 32'(next_addr));
    if (rd && pix_valid) pop_log.push_back(pix_data);

    ret = 1'b0;
    ra  = 0;
    if (mq_due.size() != 0) begin
      if (mq_due[0] <= cyc) begin
        ret = 1'b1;
        ra  = mq_addr[0];
      end
    end
    frame_start = fs;
    pix_rd      = rd;
    mem_ack     = ack;
    mem_rvalid  = ret;
    mem_rdata   = ret ? pix_of(ra) : 32'hDEAD_BEEF;
    exp_req = started && (next_addr < FP) && (stale == 0) &&
              (m_fifo.size() + mq_addr.size() < DEPTH) && !fs;
    #1;
    chk("mem_req", 32'(mem_req), 32'(exp_req));
    acc = exp_req && ack;
    if (mem_req && ack) acc_log.push_back(int'(mem_addr));

    if (ret) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (fs) begin
      m_fifo.delete();
      next_addr = 0;
      m_uflow   = 0;
      started   = 1;
      stale     = mq_addr.size();
    end else begin
      if (rd) begin
        if (m_fifo.size() != 0) void'(m_fifo.pop_front());
        else m_uflow = 1;
      end
      if (ret) begin
        if (stale > 0) stale--;
        else m_fifo.push_back(pix_of(ra));
      end
      if (acc) begin
        mq_addr.push_back(next_addr);
        mq_due.push_back(cyc + lat);
        next_addr++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; frame_start = 1'b0; pix_rd = 1'b0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(posedge clk);
    #1;
    cyc++;
    model_reset();
    chk({tag, "_req"},   32'(mem_req),   32'h0);
    chk({tag, "_addr"},  32'(mem_addr),  32'h0);
    chk({tag, "_valid"}, 32'(pix_valid), 32'h0);
    chk({tag, "_data"},  pix_data,       32'h0);
    chk({tag, "_uflow"}, 32'(underflow), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    rst = 1'b1; frame_start = 1'b0; pix_rd = 1'b0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("rst0");

    // Latency 1, ack always high, no pops: addresses 0,1,2.. until 16 held.
    lat = 1;
    cycle(1, 0, 1);
    repeat (40) cycle(0, 0, 1);
    chk("lat1_acc0", 32'(acc_log[0]), 32'd0);
    chk("lat1_acc1", 32'(acc_log[1]), 32'd1);
    chk("lat1_acc2", 32'(acc_log[2]), 32'd2);
    chk("lat1_nacc", 32'(acc_log.size()), 32'd16);
    chk("lat1_addr", 32'(mem_addr), 32'd16);
    chk("lat1_req",  32'(mem_req), 32'h0);

    // Latency 5, fill then read back 16 words in address order.
    do_reset("rst1");
    lat = 5;
    cycle(1, 0, 1);
    repeat (60) cycle(0, 0, 1);
    chk("lat5_addr", 32'(mem_addr), 32'd16);
    for (int k = 0; k < 16; k++) cycle(0, 1, 1);
    chk("lat5_npop", 32'(pop_log.size()), 32'd16);
    chk("lat5_pop0",  pop_log[0],  pix_of(0));
    chk("lat5_pop15", pop_log[15], pix_of(15));
    chk("lat5_pop0_lit", pop_log[0], 32'h00C0FFEE);

    // Pop from empty FIFO, then frame_start clears the sticky flag.
    do_reset("rst2");
    cycle(0, 1, 0);
    chk("uflow_set",  32'(underflow), 32'h1);
    chk("uflow_data", pix_data, 32'h0);
    cycle(1, 1, 0);
    chk("uflow_clr",  32'(underflow), 32'h0);

    // frame_start with 4 reads in flight: they are dropped, fetch restarts at 0.
    do_reset("rst3");
    lat = 10;
    cycle(1, 0, 0);
    repeat (4) cycle(0, 0, 1);
    acc_log.delete();
    pop_log.delete();
    cycle(1, 0, 1);
    repeat (3) cycle(0, 0, 1);
    chk("drop_noreq", 32'(acc_log.size()), 32'd0);
    for (int k = 0; k < 40; k++) cycle(0, m_fifo.size() != 0, 1);
    chk("drop_acc0", 32'(acc_log[0]), 32'd0);
    chk("drop_pop0", pop_log[0], pix_of(0));

    // Full frame, latency 3, random ack stalls, popping whenever data exists.
    do_reset("rst4");
    lat = 3;
    cycle(1, 0, 1);
    for (int i = 0; i < 3000 && pop_log.size() < FP; i++)
      cycle(0, m_fifo.size() != 0, $urandom_range(0, 3) != 0);
    errs = 0;
    foreach (pop_log[k]) if (pop_log[k] !== pix_of(k)) errs++;
    chk("frame_npop",  32'(pop_log.size()), 32'd200);
    chk("frame_order", 32'(errs), 32'd0);
    chk("frame_addr",  32'(mem_addr), 32'd200);
    chk("frame_req",   32'(mem_req), 32'h0);
    chk("frame_uflow", 32'(underflow), 32'h0);

    // Reset with 3 returns in flight; memory drops them too.
    do_reset("rst5");
    lat = 4;
    cycle(1, 0, 1);
    repeat (3) cycle(0, 0, 1);
    chk("mid_inflight", 32'(mq_addr.size()), 32'd3);
    do_reset("rst_mid");
    repeat (10) cycle(0, 0, 1);
    chk("mid_idle_req",   32'(mem_req), 32'h0);
    chk("mid_idle_valid", 32'(pix_valid), 32'h0);
    cycle(1, 0, 1);
    repeat (3) cycle(0, 0, 1);
    chk("mid_restart", 32'(acc_log[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
